// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, depth and bus field extraction for the register bank
package gpr_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH = 1 << ADDR_W_DEF;
  localparam int BUS_MAX = 256;
  localparam int FIELD_MAX = 64;
  // Field k of width w from a flattened bus, zero-extended to FIELD_MAX bits
  function automatic logic [FIELD_MAX-1:0] field(input logic [BUS_MAX-1:0] bus, input int k, input int w);
    logic [BUS_MAX-1:0] s;
    s = bus >> (k * w);
    return s[FIELD_MAX-1:0] & ((FIELD_MAX'(1) << w) - FIELD_MAX'(1));
  endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending-write flags, busy count and read-port busy
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int N = 1 << ADDR_W;
  logic [N-1:0] flag_q, flag_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic inc, dec;
  // Flag update: issue overrides a same-address write-back, flush overrides both
  always_comb begin
    flag_d = flag_q;
    if (wr_en) flag_d[wr_addr] = 1'b0;
    if (iss_en) flag_d[iss_addr] = 1'b1;
    if (flush) flag_d = '0;
  end
  assign inc = iss_en && !flag_q[iss_addr];
  assign dec = wr_en && flag_q[wr_addr] && !(iss_en && iss_addr == wr_addr);
  assign cnt_d = flush ? '0 : cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  // Flags and their population count, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
      cnt_q <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_cnt = cnt_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(field(BUS_MAX'(rd_addr), k, ADDR_W));
    assign rd_busy[k] = flag_q[a] && !(wr_en && wr_addr == a);
  end
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: parametrised register file with write-first bypass and hazard scoreboard
module gpr_bank
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [N];
  logic wr_ok, iss_ok;
  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);
  // Register array; a hard-wired zero register is simply never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else if (wr_ok) mem_q[wr_addr] <= wr_data;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(field(BUS_MAX'(rd_addr), k, ADDR_W));
    assign rd_data[k*DATA_W +: DATA_W] = reset ? '0 : (wr_ok && wr_addr == a) ? wr_data : mem_q[a];
  end
  gpr_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (rd_addr),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .iss_en  (iss_ok),
    .iss_addr(iss_addr),
    .flush   (flush),
    .rd_busy (rd_busy),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: directed scoreboard-checked bench for gpr_bank
module tb_gpr_bank;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [9:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic iss_en = 1'b0;
  logic [4:0] iss_addr = '0;
  logic flush = 1'b0;
  logic [5:0] busy_cnt;
  int passed = 0;
  int total = 0;
  typedef struct {string tag; logic [63:0] exp;} exp_t;
  exp_t q[$];

  gpr_bank dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clock = ~clock;

  task automatic ex(input string tag, input logic [63:0] e);
    q.push_back('{tag, e});
  endtask

  task automatic ck(input logic [63:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL queue_underflow observed=%0h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] d0(); return rd_data[31:0]; endfunction
  function automatic logic [31:0] d1(); return rd_data[63:32]; endfunction

  initial begin
    #12;
    ex("reset_cnt", 0); ck(64'(busy_cnt));
    ex("reset_data", 0); ck(64'(rd_data));
    @(negedge clock); reset = 1'b0;
    // write 5 and mark 10 pending, then reset mid-cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD; iss_en = 1'b1; iss_addr = 5'd10;
    @(negedge clock); idle(); rd_addr = {5'd10, 5'd5};
    #1;
    ex("pre_reset_data", 32'hDEAD); ck(64'(d0()));
    ex("pre_reset_cnt", 1); ck(64'(busy_cnt));
    ex("pre_reset_busy", 2'b10); ck(64'(rd_busy));
    #1 reset = 1'b1;
    #1;
    ex("mid_reset_data", 0); ck(64'(d0()));
    ex("mid_reset_cnt", 0); ck(64'(busy_cnt));
    ex("mid_reset_busy", 0); ck(64'(rd_busy));
    @(negedge clock); reset = 1'b0;
    #1;
    ex("post_reset_mem5", 0); ck(64'(d0()));
    // bypass on write
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234; rd_addr = {5'd0, 5'd3};
    #1;
    ex("bypass_data", 32'h1234); ck(64'(d0()));
    ex("bypass_busy", 0); ck(64'(rd_busy[0]));
    @(negedge clock); idle();
    #1;
    ex("after_write_data", 32'h1234); ck(64'(d0()));
    // zero register: no write, no bypass, no issue
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    ex("zero_nobypass", 0); ck(64'(d0()));
    @(negedge clock); idle();
    #1;
    ex("zero_mem", 0); ck(64'(d1()));
    ex("zero_cnt", 0); ck(64'(busy_cnt));
    ex("zero_busy", 0); ck(64'(rd_busy));
    // issue 7, busy only from the next cycle
    @(negedge clock);
    iss_en = 1'b1; iss_addr = 5'd7; rd_addr = {5'd0, 5'd7};
    #1;
    ex("issue_same_cycle_busy", 0); ck(64'(rd_busy[0]));
    @(negedge clock); idle();
    #1;
    ex("issue7_busy", 1); ck(64'(rd_busy[0]));
    ex("issue7_cnt", 1); ck(64'(busy_cnt));
    // write-back 7 clears busy combinationally
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    #1;
    ex("wb7_busy", 0); ck(64'(rd_busy[0]));
    ex("wb7_data", 32'h77); ck(64'(d0()));
    @(negedge clock); idle();
    #1;
    ex("wb7_cnt", 0); ck(64'(busy_cnt));
    ex("wb7_busy_after", 0); ck(64'(rd_busy[0]));
    // pending 9 and 6
    @(negedge clock); iss_en = 1'b1; iss_addr = 5'd9;
    @(negedge clock); iss_addr = 5'd6;
    @(negedge clock); idle();
    #1;
    ex("two_pending_cnt", 2); ck(64'(busy_cnt));
    // issue and write 9 together while 9 pending
    @(negedge clock);
    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    @(negedge clock); idle(); rd_addr = {5'd6, 5'd9};
    #1;
    ex("same_addr_cnt", 2); ck(64'(busy_cnt));
    ex("same_addr_busy", 2'b11); ck(64'(rd_busy));
    // issue 4 and write 6 together
    @(negedge clock);
    iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66; rd_addr = {5'd6, 5'd4};
    #1;
    ex("iss4_wb6_busy", 2'b00); ck(64'(rd_busy));
    ex("iss4_wb6_data", 32'h66); ck(64'(d1()));
    @(negedge clock); idle();
    #1;
    ex("iss4_wb6_cnt", 2); ck(64'(busy_cnt));
    ex("iss4_wb6_busy_after", 2'b01); ck(64'(rd_busy));
    // issue and write 11 together while 11 idle
    @(negedge clock);
    iss_en = 1'b1; iss_addr = 5'd11; wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hB;
    @(negedge clock); idle(); rd_addr = {5'd11, 5'd9};
    #1;
    ex("fresh_same_cnt", 3); ck(64'(busy_cnt));
    ex("fresh_same_busy", 2'b11); ck(64'(rd_busy));
    // flush clears everything
    @(negedge clock); flush = 1'b1;
    @(negedge clock); idle();
    #1;
    ex("flush_cnt", 0); ck(64'(busy_cnt));
    ex("flush_busy", 0); ck(64'(rd_busy));
    // issue 1,2,3 then flush together with write 2 and an issue
    @(negedge clock); iss_en = 1'b1; iss_addr = 5'd1;
    @(negedge clock); iss_addr = 5'd2;
    @(negedge clock); iss_addr = 5'd3;
    @(negedge clock); idle(); rd_addr = {5'd3, 5'd2};
    #1;
    ex("three_cnt", 3); ck(64'(busy_cnt));
    ex("three_busy", 2'b11); ck(64'(rd_busy));
    @(negedge clock);
    flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hABCD; iss_en = 1'b1; iss_addr = 5'd5;
    @(negedge clock); idle(); rd_addr = {5'd5, 5'd2};
    #1;
    ex("flush_wr_cnt", 0); ck(64'(busy_cnt));
    ex("flush_wr_busy", 0); ck(64'(rd_busy));
    ex("flush_wr_mem2", 32'hABCD); ck(64'(d0()));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Configurable data width, depth and read-port count, with an asynchronous reset that clears every register.
- Write-first bypass from the write-back port to all read ports.
- Per-register pending-write scoreboard for hazard detection: the decode stage marks a destination busy at issue, and write-back clears it.
- Sits between the decode stage (reads, issue) and the write-back stage of the pipeline.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and issues; 0 = register 0 is ordinary

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has a write pending
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back index
- wr_data  in  DATA_W  write-back data
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination index of the issued instruction
- flush  in  1  clear all pending flags (pipeline squash)
- busy_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all registers 0; all pending flags 0; busy_cnt 0.
  - rd_data reads 0 while reset is high; rd_busy 0.
- Reads are combinational.
  - rd_data[k] = wr_data when wr_en, wr_addr==rd_addr[k], and not (ZERO_REG and wr_addr==0).
  - Otherwise rd_data[k] = mem[rd_addr[k]].
  - This gives zero-latency write-through.
- Writes: on posedge clock, when wr_en and not (ZERO_REG and wr_addr==0), mem[wr_addr] <= wr_data.
- ZERO_REG=1: register 0 is never written; it always reads 0 with no bypass, and it is never busy.
- Pending flags (one per register), updated at posedge in this priority order:
  1. flush: all flags 0 (iss_en and wr_en are ignored for flags; the write still updates mem).
  2. iss_en and wr_en to the same address: flag = 1 (the new producer wins).
  3. iss_en: flag[iss_addr] = 1.
  4. wr_en: flag[wr_addr] = 0.
  - Issue and write to different addresses both apply in the same cycle.
  - Issue to an already-pending register leaves it 1 (single-producer model; no counting).
- rd_busy[k] = flag[rd_addr[k]] and not (wr_en and wr_addr==rd_addr[k]).
  - Data arriving this cycle via bypass is not busy.
  - Issue does not affect rd_busy until the next cycle.
- busy_cnt:
  - registered; equals the population count of the flags after the edge.
  - maintained incrementally: +1 on a 0->1 flag transition, -1 on 1->0, both possible in one cycle, net 0.
  - 0 after flush.
  - never exceeds depth (depth-ZERO_REG when ZERO_REG=1).
- Reset asserted mid-cycle clears state immediately. After reset deasserts, the first clock edge behaves normally.

Decomposition:
- Shared package gpr_pkg holds:
  - default widths DATA_W_DEF=32 and ADDR_W_DEF=5;
  - localparam DEPTH = 1<<ADDR_W;
  - a function that extracts field k from a flattened bus.
- One natural sub-module, gpr_scoreboard: pending flags, busy_cnt and rd_busy, sized by ADDR_W and NUM_RD. The data array and bypass stay in gpr_bank.

Test Plan:
- Reset: write mem[5]=0xDEAD, then pulse reset mid-cycle -> rd_data for index 5 reads 0 immediately; busy_cnt=0; rd_busy=0.
- Bypass:
  - wr_en, wr_addr=3, wr_data=0x1234 with rd_addr0=3 -> rd_data0=0x1234 in the same cycle; rd_busy0=0.
  - The next cycle, with wr_en low -> rd_data0 still 0x1234.
- Zero register, ZERO_REG=1:
  - write 0xFFFF to index 0 -> reads 0, with no bypass.
  - iss_en to index 0 -> busy_cnt stays 0.
- Scoreboard:
  - issue 7 -> next cycle rd_busy for index 7 = 1 and busy_cnt=1.
  - write 7 -> rd_busy 0 in that cycle; busy_cnt=0 after the edge.
- Simultaneous events:
  - issue 9 and write 9 in the same cycle -> flag 9 = 1; busy_cnt unchanged if it was already pending.
  - issue 4 and write 6 (6 pending) in the same cycle -> busy_cnt net 0.
- Flush: issue 1, 2, 3 -> busy_cnt=3; flush together with wr_en to 2 -> all flags 0, busy_cnt=0, mem[2] updated.
